// File: rtl/ctrl_pipe_if.sv
// Control-pipe bundle: decoded D-stage controls and E-stage ALU flags going in,
// registered E/M/W control bits and the retire counter coming out.
interface ctrl_pipe_if #(
    parameter int CNT_W = 32
);
    logic             ValidD;
    logic             RegWriteD;
    logic [1:0]       ResultSrcD;
    logic             MemWriteD;
    logic             JumpD;
    logic             BranchD;
    logic [2:0]       ALUControlD;
    logic             ALUSrcD;
    logic [2:0]       funct3D;
    logic             FlushE;
    logic             ZeroE;
    logic             LtE;
    logic             LtuE;
    logic [2:0]       ALUControlE;
    logic             ALUSrcE;
    logic             PCSrcE;
    logic             ResultSrcE0;
    logic             RegWriteM;
    logic             MemWriteM;
    logic [1:0]       ResultSrcW;
    logic             RegWriteW;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        output ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, funct3D, FlushE, ZeroE, LtE, LtuE,
        input  ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM,
               MemWriteM, ResultSrcW, RegWriteW, RetireCount
    );

    modport slave (
        input  ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, funct3D, FlushE, ZeroE, LtE, LtuE,
        output ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM,
               MemWriteM, ResultSrcW, RegWriteW, RetireCount
    );
endinterface

// File: rtl/ctrl_pipe.sv
// E/M/W control pipeline with branch resolution in E and a retire counter at W.
// Define CTRL_BRANCH_EXT_EN to decode the full funct3 branch set; otherwise taken = ZeroE.
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        reset,
    ctrl_pipe_if.slave bus
);
    logic             r_valid_e;
    logic             r_regwrite_e;
    logic [1:0]       r_resultsrc_e;
    logic             r_memwrite_e;
    logic             r_jump_e;
    logic             r_branch_e;
    logic [2:0]       r_aluctrl_e;
    logic             r_alusrc_e;

    logic             r_valid_m;
    logic             r_regwrite_m;
    logic [1:0]       r_resultsrc_m;
    logic             r_memwrite_m;

    logic             r_valid_w;
    logic             r_regwrite_w;
    logic [1:0]       r_resultsrc_w;

    logic [CNT_W-1:0] r_retire_cnt;
    logic             w_taken;
    logic             w_pcsrc;

    // Reset beats flush; a flushed or invalid slot never carries write or redirect enables.
    always_ff @(posedge clk) begin
        if (!reset || bus.FlushE) begin
            r_valid_e     <= 1'b0;
            r_regwrite_e  <= 1'b0;
            r_resultsrc_e <= 2'b00;
            r_memwrite_e  <= 1'b0;
            r_jump_e      <= 1'b0;
            r_branch_e    <= 1'b0;
            r_aluctrl_e   <= 3'b000;
            r_alusrc_e    <= 1'b0;
        end else begin
            r_valid_e     <= bus.ValidD;
            r_regwrite_e  <= bus.RegWriteD & bus.ValidD;
            r_resultsrc_e <= bus.ResultSrcD;
            r_memwrite_e  <= bus.MemWriteD & bus.ValidD;
            r_jump_e      <= bus.JumpD & bus.ValidD;
            r_branch_e    <= bus.BranchD & bus.ValidD;
            r_aluctrl_e   <= bus.ALUControlD;
            r_alusrc_e    <= bus.ALUSrcD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_m     <= 1'b0;
            r_regwrite_m  <= 1'b0;
            r_resultsrc_m <= 2'b00;
            r_memwrite_m  <= 1'b0;
            r_valid_w     <= 1'b0;
            r_regwrite_w  <= 1'b0;
            r_resultsrc_w <= 2'b00;
        end else begin
            r_valid_m     <= r_valid_e;
            r_regwrite_m  <= r_regwrite_e;
            r_resultsrc_m <= r_resultsrc_e;
            r_memwrite_m  <= r_memwrite_e;
            r_valid_w     <= r_valid_m;
            r_regwrite_w  <= r_regwrite_m;
            r_resultsrc_w <= r_resultsrc_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (r_valid_w) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

`ifdef CTRL_BRANCH_EXT_EN
    logic [2:0] r_funct3_e;

    always_ff @(posedge clk) begin
        if (!reset || bus.FlushE) begin
            r_funct3_e <= 3'b000;
        end else begin
            r_funct3_e <= bus.funct3D;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_funct3_e)
            3'b000:  w_taken = bus.ZeroE;
            3'b001:  w_taken = ~bus.ZeroE;
            3'b100:  w_taken = bus.LtE;
            3'b101:  w_taken = ~bus.LtE;
            3'b110:  w_taken = bus.LtuE;
            3'b111:  w_taken = ~bus.LtuE;
            default: w_taken = 1'b0;
        endcase
    end
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{bus.funct3D, bus.LtE, bus.LtuE};
    assign w_taken     = bus.ZeroE;
`endif

    assign w_pcsrc = r_valid_e & (r_jump_e | (r_branch_e & w_taken));

    assign bus.ALUControlE = r_aluctrl_e;
    assign bus.ALUSrcE     = r_alusrc_e;
    assign bus.PCSrcE      = w_pcsrc;
    assign bus.ResultSrcE0 = r_resultsrc_e[0];
    assign bus.RegWriteM   = r_regwrite_m;
    assign bus.MemWriteM   = r_memwrite_m;
    assign bus.ResultSrcW  = r_resultsrc_w;
    assign bus.RegWriteW   = r_regwrite_w;
    assign bus.RetireCount = r_retire_cnt;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected E/M/W bundles queued as D is driven,
// compared against the pipe outputs after every edge, plus directed branch/flush/wrap cases.
module tb_ctrl_pipe;
    localparam int CW = 4;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic [2:0] aluctrl;
        logic       alusrc;
        logic [2:0] funct3;
    } bun_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bun_t          exp_q[$];
    logic [CW-1:0] exp_cnt;

    ctrl_pipe_if #(.CNT_W(CW)) bus ();

    ctrl_pipe #(.CNT_W(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bun_t mk(input logic v, input logic rw, input logic [1:0] rs,
                                input logic mw, input logic j, input logic b,
                                input logic [2:0] alu, input logic as, input logic [2:0] f3);
        bun_t t;
        t = '{v, rw, rs, mw, j, b, alu, as, f3};
        return t;
    endfunction

    function automatic logic f_taken(input logic [2:0] f3, input logic z, input logic lt,
                                     input logic ltu);
`ifdef CTRL_BRANCH_EXT_EN
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return lt;
            3'b101:  return ~lt;
            3'b110:  return ltu;
            3'b111:  return ~ltu;
            default: return 1'b0;
        endcase
`else
        // flags other than Zero do not influence the base build
        return z | (1'b0 & (lt | ltu | ^f3));
`endif
    endfunction

    task automatic pc_chk(input string tag, input logic z, input logic lt, input logic ltu,
                          input logic exp);
        bus.ZeroE = z;
        bus.LtE   = lt;
        bus.LtuE  = ltu;
        #1;
        chk(tag, bus.PCSrcE, exp);
    endtask

    task automatic cycle(input bun_t d, input logic flush, input logic rst_n);
        bun_t de;
        bun_t e;
        bun_t m;
        bun_t w;
        bun_t w_before;
        logic z, lt, ltu;
        bus.ValidD      = d.valid;
        bus.RegWriteD   = d.regwrite;
        bus.ResultSrcD  = d.resultsrc;
        bus.MemWriteD   = d.memwrite;
        bus.JumpD       = d.jump;
        bus.BranchD     = d.branch;
        bus.ALUControlD = d.aluctrl;
        bus.ALUSrcD     = d.alusrc;
        bus.funct3D     = d.funct3;
        bus.FlushE      = flush;
        reset           = rst_n;
        w_before        = exp_q[0];
        @(posedge clk);
        if (!rst_n) begin
            exp_cnt = '0;
            exp_q   = '{bun_t'(0), bun_t'(0), bun_t'(0)};
        end else begin
            if (w_before.valid) exp_cnt = exp_cnt + 1'b1;
            de = flush ? bun_t'(0) : d;
            if (!de.valid) begin
                de.regwrite = 1'b0;
                de.memwrite = 1'b0;
                de.jump     = 1'b0;
                de.branch   = 1'b0;
            end
            exp_q.push_back(de);
            void'(exp_q.pop_front());
        end
        w = exp_q[0];
        m = exp_q[1];
        e = exp_q[2];
        #1;
        chk("alu_ctrl_e", bus.ALUControlE, e.aluctrl);
        chk("alu_src_e", bus.ALUSrcE, e.alusrc);
        chk("res_src_e0", bus.ResultSrcE0, e.resultsrc[0]);
        chk("reg_write_m", bus.RegWriteM, m.regwrite);
        chk("mem_write_m", bus.MemWriteM, m.memwrite);
        chk("res_src_w", bus.ResultSrcW, w.resultsrc);
        chk("reg_write_w", bus.RegWriteW, w.regwrite);
        chk("retire_cnt", bus.RetireCount, exp_cnt);
        z   = 1'($urandom);
        lt  = 1'($urandom);
        ltu = 1'($urandom);
        pc_chk("pcsrc_rand", z, lt, ltu,
               e.valid & (e.jump | (e.branch & f_taken(e.funct3, z, lt, ltu))));
        @(negedge clk);
    endtask

    initial begin
        bun_t          bub;
        bun_t          nop;
        bun_t          lw;
        bun_t          sw;
        bun_t          br;
        bun_t          rd;
        logic [CW-1:0] saved_cnt;
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = '0;
        exp_q    = '{bun_t'(0), bun_t'(0), bun_t'(0)};
        bub = '0;
        nop = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
        lw  = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b010);
        sw  = mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b010);
        reset    = 1'b0;
        bus.ZeroE = 1'b1;
        bus.LtE   = 1'b1;
        bus.LtuE  = 1'b1;

        // reset with garbage on the D inputs
        for (int i = 0; i < 2; i++) cycle(bun_t'(14'($urandom)), 1'($urandom), 1'b0);
        chk("rst_reg_write_w", bus.RegWriteW, 0);
        chk("rst_retire", bus.RetireCount, 0);
        pc_chk("rst_pcsrc", 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) cycle(nop, 1'b0, 1'b1);
        chk("first_retire", bus.RetireCount, 1);
        for (int i = 0; i < 3; i++) cycle(bub, 1'b0, 1'b1);

        cycle(lw, 1'b0, 1'b1);
        chk("lw_res_src_e0", bus.ResultSrcE0, 1);
        chk("lw_alu_src_e", bus.ALUSrcE, 1);
        cycle(bub, 1'b0, 1'b1);
        chk("lw_reg_write_m", bus.RegWriteM, 1);
        cycle(bub, 1'b0, 1'b1);
        chk("lw_res_src_w", bus.ResultSrcW, 2'b01);
        chk("lw_reg_write_w", bus.RegWriteW, 1);
        for (int i = 0; i < 2; i++) cycle(bub, 1'b0, 1'b1);

        saved_cnt = exp_cnt;
        cycle(sw, 1'b1, 1'b1);
        cycle(bub, 1'b0, 1'b1);
        chk("flush_mem_write_m", bus.MemWriteM, 0);
        for (int i = 0; i < 3; i++) cycle(bub, 1'b0, 1'b1);
        chk("flush_retire", bus.RetireCount, saved_cnt);

        // flush while older instructions sit in M and W
        cycle(sw, 1'b0, 1'b1);
        cycle(lw, 1'b0, 1'b1);
        cycle(nop, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(bub, 1'b0, 1'b1);

        br = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001);
        cycle(br, 1'b0, 1'b1);
`ifdef CTRL_BRANCH_EXT_EN
        pc_chk("bne_zero1", 1'b1, 1'b0, 1'b0, 1'b0);
        pc_chk("bne_zero0", 1'b0, 1'b0, 1'b0, 1'b1);
`else
        pc_chk("beq_zero1", 1'b1, 1'b0, 1'b0, 1'b1);
        pc_chk("beq_zero0", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        br.funct3 = 3'b110;
        cycle(br, 1'b0, 1'b1);
`ifdef CTRL_BRANCH_EXT_EN
        pc_chk("bltu_lt1", 1'b0, 1'b0, 1'b1, 1'b1);
`else
        pc_chk("bltu_lt1", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        br.funct3 = 3'b010;
        cycle(br, 1'b0, 1'b1);
`ifdef CTRL_BRANCH_EXT_EN
        pc_chk("f3_010", 1'b1, 1'b1, 1'b1, 1'b0);
`else
        pc_chk("f3_010", 1'b1, 1'b1, 1'b1, 1'b1);
`endif
        br.funct3 = 3'b000;
        br.valid  = 1'b0;
        cycle(br, 1'b0, 1'b1);
        pc_chk("invalid_branch", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000), 1'b0, 1'b1);
        pc_chk("jump_zero0", 1'b0, 1'b0, 1'b0, 1'b1);
        pc_chk("jump_zero1", 1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            rd = bun_t'(14'($urandom));
            cycle(rd, ($urandom_range(0, 4) == 0), 1'b1);
        end

        cycle(bub, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(nop, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(bub, 1'b0, 1'b1);
        chk("wrap_retire", bus.RetireCount, 1);

        for (int i = 0; i < 3; i++) cycle(nop, 1'b0, 1'b1);
        cycle(nop, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(bub, 1'b0, 1'b1);
        chk("rst_drop_retire", bus.RetireCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
